// File: rtl/forthsuper_pkg.sv
// Shared definitions for the TIB scanner.
// Contents: scan FSM state encoding, ASCII constants used by the token
// rules, and the delimiter classifier.
package forthsuper_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SKIP = 2'd1;
    localparam logic [1:0] ST_SCAN = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        SKIP = ST_SKIP,
        SCAN = ST_SCAN,
        DONE = ST_DONE
    } scan_st_t;

    localparam logic [7:0] NUL   = 8'h00;
    localparam logic [7:0] SPC   = 8'h20;
    localparam logic [7:0] ZERO  = 8'h30;
    localparam logic [7:0] NINE  = 8'h39;
    localparam logic [7:0] MINUS = 8'h2D;

    // Every control character and space separates tokens; NUL ends the buffer.
    function automatic logic is_delim(input logic [7:0] b);
        return (b != NUL) && (b <= SPC);
    endfunction

endpackage

// File: rtl/mb8_io.sv
// Byte-wide memory bus between a master and a single-port RAM.
// Signals: we (write enable), ai (address), vi (write data) from the master;
// vo (read data, one cycle after ai) from the slave.
interface mb8_io #(
    parameter int ASZ = 17,
    parameter int DSZ = 8
);
    logic           we;
    logic [ASZ-1:0] ai;
    logic [DSZ-1:0] vi;
    logic [DSZ-1:0] vo;

    modport master (output we, output ai, output vi, input vo);
    modport slave  (input we, input ai, input vi, output vo);
endinterface

// File: rtl/dec_acc.sv
// Decimal literal accumulator for one token.
// Ports: clk, rst (sync, active high); clr starts a new token; en feeds the
// byte on digit; neg marks the byte position where a '-' sign is legal.
// Outputs: val (signed result, mod 2^VSZ) and ok (token so far is a valid
// decimal literal with at least one digit). Outputs reflect bytes fed up to
// the previous clock.
module dec_acc
    import forthsuper_pkg::*;
#(
    parameter int VSZ = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           en,
    input  logic [7:0]     digit,
    input  logic           neg,
    output logic [VSZ-1:0] val,
    output logic           ok
);

    logic [VSZ-1:0] mag_reg, mag_next, base_mag, dval;
    logic           ok_reg, ok_next;
    logic           minus_reg, minus_next;
    logic           dig_reg, dig_next;
    logic           is_dig;

    always_comb begin
        is_dig   = (digit >= ZERO) && (digit <= NINE);
        dval     = VSZ'(digit - ZERO);
        // clr and en may coincide: the first byte is applied to a clean state.
        base_mag   = clr ? '0 : mag_reg;
        mag_next   = base_mag;
        ok_next    = clr ? 1'b1 : ok_reg;
        minus_next = clr ? 1'b0 : minus_reg;
        dig_next   = clr ? 1'b0 : dig_reg;
        if (en) begin
            if (is_dig) begin
                // val*10 + d without a multiplier
                mag_next = (base_mag << 3) + (base_mag << 1) + dval;
                dig_next = 1'b1;
            end else if (neg && (digit == MINUS)) begin
                minus_next = 1'b1;
            end else begin
                ok_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mag_reg   <= '0;
            ok_reg    <= 1'b0;
            minus_reg <= 1'b0;
            dig_reg   <= 1'b0;
        end else begin
            mag_reg   <= mag_next;
            ok_reg    <= ok_next;
            minus_reg <= minus_next;
            dig_reg   <= dig_next;
        end
    end

    assign val = minus_reg ? ('0 - mag_reg) : mag_reg;
    assign ok  = ok_reg & dig_reg;

endmodule

// File: rtl/tib_scanner.sv
// Terminal input buffer scanner: reads bytes over mb8_io starting at adr,
// skips delimiters and isolates one whitespace-delimited token.
// Ports: clk, rst (sync, active high), b8_if (read-only bus master), start/adr
// (begin a scan), bsy (scan running), tok_vld (1-cycle result strobe) with
// eol, err, tok_adr, tok_len, tok_num, tok_val, nxt (next scan address).
module tib_scanner
    import forthsuper_pkg::*;
#(
    parameter int ASZ  = 17,
    parameter int DSZ  = 8,
    parameter int TLEN = 31,
    parameter int VSZ  = 32
) (
    input  logic           clk,
    input  logic           rst,
    mb8_io.master          b8_if,
    input  logic           start,
    input  logic [ASZ-1:0] adr,
    output logic           bsy,
    output logic           tok_vld,
    output logic           eol,
    output logic           err,
    output logic [ASZ-1:0] tok_adr,
    output logic [7:0]     tok_len,
    output logic           tok_num,
    output logic [VSZ-1:0] tok_val,
    output logic [ASZ-1:0] nxt
);

    localparam logic [7:0] TLEN_L = 8'(TLEN);

    scan_st_t       state_reg;
    logic [ASZ-1:0] ai_reg;
    logic           prime_reg;   // first streaming cycle: no byte returned yet
    logic [DSZ-1:0] rd_byte;
    logic [ASZ-1:0] byte_adr;
    logic           eval, is_nul, is_tok;
    logic           acc_clr, acc_en, acc_ok;
    logic [VSZ-1:0] acc_val;

    assign rd_byte  = b8_if.vo;
    // The byte being evaluated was issued one cycle ago.
    assign byte_adr = ai_reg - ASZ'(1);
    assign eval     = ((state_reg == SKIP) || (state_reg == SCAN)) && !prime_reg;
    assign is_nul   = (rd_byte == NUL);
    assign is_tok   = !is_nul && !is_delim(rd_byte);
    assign acc_clr  = eval && (state_reg == SKIP) && is_tok;
    assign acc_en   = eval && is_tok && ((state_reg == SKIP) || (tok_len < TLEN_L));

    dec_acc #(.VSZ(VSZ)) u_acc (
        .clk   (clk),
        .rst   (rst),
        .clr   (acc_clr),
        .en    (acc_en),
        .digit (rd_byte),
        .neg   (acc_clr),
        .val   (acc_val),
        .ok    (acc_ok)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            ai_reg    <= '0;
            prime_reg <= 1'b0;
            eol       <= 1'b0;
            err       <= 1'b0;
            tok_adr   <= '0;
            tok_len   <= '0;
            tok_num   <= 1'b0;
            tok_val   <= '0;
            nxt       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= SKIP;
                        ai_reg    <= adr;
                        prime_reg <= 1'b1;
                    end
                end
                SKIP: begin
                    prime_reg <= 1'b0;
                    if (prime_reg || !is_nul) begin
                        ai_reg <= ai_reg + ASZ'(1);
                    end
                    if (!prime_reg) begin
                        if (is_nul) begin
                            state_reg <= DONE;
                            eol       <= 1'b1;
                            err       <= 1'b0;
                            tok_adr   <= byte_adr;
                            tok_len   <= '0;
                            tok_num   <= 1'b0;
                            tok_val   <= '0;
                            nxt       <= byte_adr;
                        end else if (is_tok) begin
                            state_reg <= SCAN;
                            tok_adr   <= byte_adr;
                            tok_len   <= 8'd1;
                        end
                    end
                end
                SCAN: begin
                    if (!is_tok || (tok_len == TLEN_L)) begin
                        // Token ends here; ai is not advanced so only one
                        // address past the terminating byte is ever issued.
                        state_reg <= DONE;
                        eol       <= 1'b0;
                        err       <= is_tok;
                        tok_num   <= acc_ok;
                        tok_val   <= acc_ok ? acc_val : '0;
                        nxt       <= (is_tok || is_nul) ? byte_adr : ai_reg;
                    end else begin
                        ai_reg  <= ai_reg + ASZ'(1);
                        tok_len <= tok_len + 8'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bsy       = (state_reg == SKIP) || (state_reg == SCAN);
    assign tok_vld   = (state_reg == DONE);
    assign b8_if.we  = 1'b0;
    assign b8_if.ai  = ai_reg;
    assign b8_if.vi  = '0;

endmodule
